// File: rtl/mesh_sort_pkg.sv
// Shared constants and types for the mesh sorting array.
// Imported by the sequencer and the PE array top.
package mesh_sort_pkg;

    localparam logic [3:0] HALF_ODD   = 4'd0;
    localparam logic [3:0] HALF_EVEN  = 4'd1;
    localparam logic [3:0] FULL_ODD   = 4'd2;
    localparam logic [3:0] FULL_EVEN  = 4'd3;
    localparam logic [3:0] COL_ODD    = 4'd4;
    localparam logic [3:0] COL_EVEN   = 4'd5;
    localparam logic [3:0] SNAKE_ODD  = 4'd6;
    localparam logic [3:0] SNAKE_EVEN = 4'd7;
    localparam logic [3:0] NOP        = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HALF,
        S_FULL,
        S_COL,
        S_FINAL,
        S_DONE
    } fsm_e;

    typedef enum logic [1:0] {
        PH_HALF  = 2'd0,
        PH_FULL  = 2'd1,
        PH_COL   = 2'd2,
        PH_FINAL = 2'd3
    } phase_e;

    // Busy cycles of one sort: LOAD plus every transposition step.
    function automatic int total_steps(int rows, int cols, int rounds);
        return 1 + rounds * (2 * cols + rows) + cols;
    endfunction

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mesh_sort_ctrl_if.sv
// Host/PE-facing bundle of the mesh sort sequencer.
// master is the sequencer side, slave the host/array side.
interface mesh_sort_ctrl_if;
    import mesh_sort_pkg::*;

    logic       start;
    logic       pe_load;
    logic [3:0] state;
    logic       busy;
    logic       done;
    phase_e     phase;

    modport master (
        input  start,
        output pe_load,
        output state,
        output busy,
        output done,
        output phase
    );

    modport slave (
        output start,
        input  pe_load,
        input  state,
        input  busy,
        input  done,
        input  phase
    );

endinterface

// File: rtl/mesh_step_counter.sv
// Phase step counter: load captures the terminal count and clears.
// last flags the final step of the current phase.
module mesh_step_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         odd,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] term_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            term_q <= '0;
        end else if (ld) begin
            cnt_q  <= '0;
            term_q <= term;
        end else if (en) begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign odd  = cnt_q[0];
    assign last = (cnt_q == term_q);

endmodule

// File: rtl/mesh_sort_ctrl.sv
// Mesh sort sequencer: drives PE state codes through the
// half/full/column rounds and a final row pass.
module mesh_sort_ctrl
    import mesh_sort_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ROUNDS = 3
) (
    input  logic              clk,
    input  logic              rst,
    mesh_sort_ctrl_if.master  bus
);

    localparam int SW = $clog2(max2(ROWS, COLS)) + 1;
    localparam int RW = $clog2(ROUNDS) + 1;

    fsm_e          fsm_q;
    logic [RW-1:0] round_q;
    logic          odd;
    logic          last;
    logic          sorting;
    logic          ld;
    logic [SW-1:0] term;

    assign sorting = (fsm_q == S_HALF) || (fsm_q == S_FULL) ||
                     (fsm_q == S_COL)  || (fsm_q == S_FINAL);

    // Reload on every phase entry; the next phase length follows the current one.
    assign ld   = (fsm_q == S_LOAD) ||
                  (sorting && last && fsm_q != S_FINAL);
    assign term = (fsm_q == S_FULL) ? SW'(ROWS - 1) : SW'(COLS - 1);

    mesh_step_counter #(
        .W (SW)
    ) u_step (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .en   (sorting),
        .term (term),
        .odd  (odd),
        .last (last)
    );

    // Outputs are decoded from the current state, so they trail it by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= S_IDLE;
            round_q     <= '0;
            bus.pe_load <= 1'b0;
            bus.state   <= NOP;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.phase   <= PH_HALF;
        end else begin
            bus.pe_load <= 1'b0;
            bus.state   <= NOP;
            bus.busy    <= 1'b1;
            bus.done    <= 1'b0;
            bus.phase   <= PH_HALF;
            unique case (fsm_q)
                S_IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.start) fsm_q <= S_LOAD;
                end
                S_LOAD: begin
                    bus.pe_load <= 1'b1;
                    round_q     <= '0;
                    fsm_q       <= S_HALF;
                end
                S_HALF: begin
                    bus.state <= HALF_ODD | {3'b000, odd};
                    if (last) fsm_q <= S_FULL;
                end
                S_FULL: begin
                    bus.state <= FULL_ODD | {3'b000, odd};
                    bus.phase <= PH_FULL;
                    if (last) fsm_q <= S_COL;
                end
                S_COL: begin
                    bus.state <= COL_ODD | {3'b000, odd};
                    bus.phase <= PH_COL;
                    if (last) begin
                        if (round_q == RW'(ROUNDS - 1)) begin
                            fsm_q <= S_FINAL;
                        end else begin
                            round_q <= round_q + 1'b1;
                            fsm_q   <= S_HALF;
                        end
                    end
                end
                S_FINAL: begin
                    bus.state <= FULL_ODD | {3'b000, odd};
                    bus.phase <= PH_FINAL;
                    if (last) fsm_q <= S_DONE;
                end
                S_DONE: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    fsm_q    <= S_IDLE;
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_sort_ctrl.sv
// Directed bench for mesh_sort_ctrl: default 4x4x3 instance
// plus a 2x6x2 instance sharing clock, reset and start.
module tb_mesh_sort_ctrl;
    import mesh_sort_pkg::*;

    localparam logic [8:0] IDLE_V = 9'h00F;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] exp1[$];
    logic [8:0] exp2[$];

    always #5 clk = ~clk;

    mesh_sort_ctrl_if b1 ();
    mesh_sort_ctrl_if b2 ();

    assign b1.start = start;
    assign b2.start = start;

    mesh_sort_ctrl #(
        .ROWS   (4),
        .COLS   (4),
        .ROUNDS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    mesh_sort_ctrl #(
        .ROWS   (2),
        .COLS   (6),
        .ROUNDS (2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    // {pe_load, busy, done, phase, state}
    function automatic logic [8:0] v1();
        return {b1.pe_load, b1.busy, b1.done, b1.phase, b1.state};
    endfunction

    function automatic logic [8:0] v2();
        return {b2.pe_load, b2.busy, b2.done, b2.phase, b2.state};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected output vector per cycle, from LOAD through DONE.
    task automatic build(input int rows, input int cols,
                         input int rounds, input bit sel);
        logic [8:0] q[$];
        q.push_back({3'b100 | 3'b010, 2'd0, 4'hF});
        for (int r = 0; r < rounds; r++) begin
            for (int s = 0; s < cols; s++)
                q.push_back({3'b010, 2'd0, 4'(s % 2)});
            for (int s = 0; s < cols; s++)
                q.push_back({3'b010, 2'd1, 4'(2 + s % 2)});
            for (int s = 0; s < rows; s++)
                q.push_back({3'b010, 2'd2, 4'(4 + s % 2)});
        end
        for (int s = 0; s < cols; s++)
            q.push_back({3'b010, 2'd3, 4'(2 + s % 2)});
        q.push_back({3'b001, 2'd0, 4'hF});
        if (sel) exp2 = q;
        else exp1 = q;
    endtask

    task automatic run_seq(input int pulse_at, input bit hold,
                           input bit chk2, input string tag);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk({tag, "_pre"}, v1(), IDLE_V);
        if (chk2) chk({tag, "_pre2"}, v2(), IDLE_V);
        for (int i = 0; i < exp1.size(); i++) begin
            @(negedge clk);
            if (i == pulse_at) start = 1'b1;
            else if (!hold) start = 1'b0;
            chk($sformatf("%s_a%0d", tag, i), v1(), exp1[i]);
            if (chk2)
                chk($sformatf("%s_b%0d", tag, i), v2(), exp2[i]);
        end
        if (!hold) begin
            @(negedge clk);
            chk({tag, "_post"}, v1(), IDLE_V);
            if (chk2) chk({tag, "_post2"}, v2(), IDLE_V);
        end
    endtask

    initial begin
        build(4, 4, 3, 1'b0);
        build(2, 6, 2, 1'b1);
        while (exp2.size() < exp1.size()) exp2.push_back(IDLE_V);

        // reset held for three cycles
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a", v1(), IDLE_V);
        chk("rst_b", v2(), IDLE_V);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_a", v1(), IDLE_V);

        // plain run, both instances
        run_seq(-1, 1'b0, 1'b1, "run");

        // start pulse while busy is ignored
        run_seq(10, 1'b0, 1'b1, "busy_start");

        // asynchronous reset in the column phase
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("mid_%0d", i), v1(), exp1[i]);
        end
        #2 rst = 1'b0;
        #1;
        chk("async_rst_a", v1(), IDLE_V);
        chk("async_rst_b", v2(), IDLE_V);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_seq(-1, 1'b0, 1'b1, "after_rst");

        // start held high: back-to-back runs with one idle cycle
        run_seq(-1, 1'b1, 1'b0, "held0");
        run_seq(-1, 1'b1, 1'b0, "held1");
        run_seq(-1, 1'b0, 1'b0, "held2");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
